// File: rtl/cu_sequencer_pkg.sv
// Shared constants for the cu_sequencer control unit.
// Opcode map, ALU codes, MUX selects and FSM states.
package cu_sequencer_pkg;

   typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_NOT = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_SHL = 3'b110;
   localparam logic [2:0] ALU_SHR = 3'b111;

   localparam logic [1:0] SA_A    = 2'b00;
   localparam logic [1:0] SA_B    = 2'b01;
   localparam logic [1:0] SA_ZERO = 2'b11;
   localparam logic [1:0] SB_B    = 2'b00;
   localparam logic [1:0] SB_A    = 2'b01;
   localparam logic [1:0] SB_LIT  = 2'b10;

   localparam logic [4:0] G_MOV = 5'd0;
   localparam logic [4:0] G_ADD = 5'd1;
   localparam logic [4:0] G_SUB = 5'd2;
   localparam logic [4:0] G_AND = 5'd3;
   localparam logic [4:0] G_OR  = 5'd4;
   localparam logic [4:0] G_NOT = 5'd5;
   localparam logic [4:0] G_XOR = 5'd6;
   localparam logic [4:0] G_SHL = 5'd7;
   localparam logic [4:0] G_SHR = 5'd8;
   localparam logic [4:0] G_INC = 5'd9;

   localparam logic [6:0] OP_ALU_MAX = 7'h24;
   localparam logic [6:0] OP_JMP = 7'h40;
   localparam logic [6:0] OP_JEQ = 7'h41;
   localparam logic [6:0] OP_JNE = 7'h42;
   localparam logic [6:0] OP_JCS = 7'h43;
   localparam logic [6:0] OP_JMI = 7'h44;
   localparam logic [6:0] OP_HLT = 7'h7F;

   function automatic logic [2:0] grp_alu(input logic [4:0] g);
      unique case (g)
         G_MOV:   grp_alu = ALU_OR;
         G_ADD:   grp_alu = ALU_ADD;
         G_SUB:   grp_alu = ALU_SUB;
         G_AND:   grp_alu = ALU_AND;
         G_OR:    grp_alu = ALU_OR;
         G_NOT:   grp_alu = ALU_NOT;
         G_XOR:   grp_alu = ALU_XOR;
         G_SHL:   grp_alu = ALU_SHL;
         G_SHR:   grp_alu = ALU_SHR;
         default: grp_alu = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// Instruction-memory fetch port of the cu_sequencer.
// master = sequencer side, slave = memory side.
interface cu_sequencer_if #(
   parameter int OPW = 7,
   parameter int DW  = 8,
   parameter int PCW = 8
) ();
   logic [PCW-1:0]    im_addr;
   logic              im_req;
   logic              im_ack;
   logic [OPW+DW-1:0] im_data;

   modport master (output im_addr, im_req, input im_ack, im_data);
   modport slave  (input im_addr, im_req, output im_ack, im_data);
endinterface

// File: rtl/cu_sequencer_decode.sv
// Combinational opcode decoder for cu_sequencer.
// Jump opcodes decode only when CU_JUMP_EN is defined.
module cu_decode
   import cu_sequencer_pkg::*;
#(
   parameter int OPW = 7
) (
   input  logic [OPW-1:0] opcode,
   output logic           la,
   output logic           lb,
   output logic [1:0]     sa,
   output logic [1:0]     sb,
   output logic [2:0]     alu_s,
   output logic           is_alu,
   output logic           is_mov,
   output logic           is_jmp,
   output logic           is_hlt,
   output logic           illegal
);
   logic       hi_bad;
   logic [6:0] op7;
   logic [4:0] grp;
   logic [1:0] v;
   logic       unary;

   if (OPW > 7) begin : g_hi
      assign hi_bad = |opcode[OPW-1:7];
   end else begin : g_nohi
      assign hi_bad = 1'b0;
   end

   assign op7   = opcode[6:0];
   assign grp   = op7[6:2];
   assign v     = op7[1:0];
   assign unary = (grp == G_NOT) || (grp == G_SHL) || (grp == G_SHR);

   always_comb begin
      la      = 1'b0;
      lb      = 1'b0;
      sa      = SA_A;
      sb      = SB_B;
      alu_s   = ALU_ADD;
      is_alu  = 1'b0;
      is_mov  = 1'b0;
      is_jmp  = 1'b0;
      is_hlt  = 1'b0;
      illegal = 1'b0;
      if (hi_bad) begin
         illegal = 1'b1;
      end else if (op7 <= OP_ALU_MAX) begin
         is_alu = 1'b1;
         alu_s  = grp_alu(grp);
         if (grp == G_MOV) begin
            is_mov = 1'b1;
            la = ~v[0];
            lb = v[0];
            sa = SA_ZERO;
            sb = v[1] ? SB_LIT : (v[0] ? SB_A : SB_B);
         end else if (grp == G_INC) begin
            lb = 1'b1;
            sa = SA_B;
            sb = SB_LIT;
         end else if (unary) begin
            // variant bit1 picks destination, bit0 picks source
            la = ~v[1];
            lb = v[1];
            sa = v[0] ? SA_B : SA_A;
         end else begin
            la = ~v[0];
            lb = v[0];
            sa = (v == 2'd3) ? SA_B : SA_A;
            sb = v[1] ? SB_LIT : SB_B;
         end
      end else if (op7 == OP_HLT) begin
         is_hlt = 1'b1;
`ifdef CU_JUMP_EN
      end else if (op7 >= OP_JMP && op7 <= OP_JMI) begin
         is_jmp = 1'b1;
`endif
      end else begin
         illegal = 1'b1;
      end
   end
endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle fetch/exec control sequencer; define CU_JUMP_EN
// to enable the conditional jump opcodes 0x40-0x44.
module cu_sequencer
   import cu_sequencer_pkg::*;
#(
   parameter int OPW      = 7,
   parameter int DW       = 8,
   parameter int PCW      = 8,
   parameter int RESET_PC = 0
) (
   input  logic           clk,
   input  logic           rst,
   cu_sequencer_if.master im,
   input  logic           alu_z,
   input  logic           alu_n,
   input  logic           alu_c,
   output logic           LA,
   output logic           LB,
   output logic [1:0]     SA,
   output logic [1:0]     SB,
   output logic [2:0]     alu_s,
   output logic [DW-1:0]  lit,
   output logic [PCW-1:0] pc,
   output logic           halt,
   output logic           err
);
   state_t            state, state_n;
   logic [OPW+DW-1:0] ir;
   logic [OPW-1:0]    ir_op;
   logic [DW-1:0]     ir_lit;
   logic              flag_z, flag_n, flag_c;
   logic              d_la, d_lb, d_alu, d_mov, d_jmp, d_hlt, d_ill;
   logic [1:0]        d_sa, d_sb;
   logic [2:0]        d_alu_s;
   logic [PCW-1:0]    tgt;
   logic              take;

   assign ir_op  = ir[OPW+DW-1:DW];
   assign ir_lit = ir[DW-1:0];

   cu_decode #(.OPW(OPW)) u_dec (
      .opcode  (ir_op),
      .la      (d_la),
      .lb      (d_lb),
      .sa      (d_sa),
      .sb      (d_sb),
      .alu_s   (d_alu_s),
      .is_alu  (d_alu),
      .is_mov  (d_mov),
      .is_jmp  (d_jmp),
      .is_hlt  (d_hlt),
      .illegal (d_ill)
   );

   if (DW >= PCW) begin : g_tgt_trunc
      assign tgt = ir_lit[PCW-1:0];
   end else begin : g_tgt_zext
      assign tgt = {{(PCW-DW){1'b0}}, ir_lit};
   end

   always_comb begin
      take = 1'b0;
      unique case (ir_op[6:0])
         OP_JMP:  take = 1'b1;
         OP_JEQ:  take = flag_z;
         OP_JNE:  take = ~flag_z;
         OP_JCS:  take = flag_c;
         OP_JMI:  take = flag_n;
         default: take = 1'b0;
      endcase
      take = take & d_jmp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= FETCH;
         pc     <= PCW'(RESET_PC);
         ir     <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_c <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= state_n;
         if (state == FETCH && im.im_ack) ir <= im.im_data;
         if (state == EXEC && !d_hlt) begin
            pc <= take ? tgt : pc + 1'b1;
            if (d_alu && !d_mov) begin
               flag_z <= alu_z;
               flag_n <= alu_n;
               flag_c <= alu_c;
            end
            if (d_ill) err <= 1'b1;
         end
      end
   end

   always_comb begin
      state_n   = state;
      im.im_req = 1'b0;
      LA        = 1'b0;
      LB        = 1'b0;
      SA        = SA_A;
      SB        = SB_B;
      alu_s     = ALU_ADD;
      halt      = 1'b0;
      lit       = ir_lit;
      unique case (state)
         FETCH: begin
            im.im_req = 1'b1;
            if (im.im_ack) state_n = EXEC;
         end
         EXEC: begin
            // register loads must never fire in a reset cycle
            LA      = d_la & ~rst;
            LB      = d_lb & ~rst;
            SA      = d_sa;
            SB      = d_sb;
            alu_s   = d_alu_s;
            state_n = d_hlt ? HALT : FETCH;
         end
         HALT: begin
            halt = 1'b1;
            lit  = '0;
         end
         default: state_n = FETCH;
      endcase
   end

   assign im.im_addr = pc;
endmodule

// File: tb/tb_cu_sequencer.sv
// Directed self-checking bench for cu_sequencer.
// Jump checks follow CU_JUMP_EN; otherwise 0x40 must flag err.
module tb_cu_sequencer;
   logic       clk = 1'b0;
   logic       rst;
   logic       alu_z, alu_n, alu_c;
   logic       LA, LB, halt, err;
   logic [1:0] SA, SB;
   logic [2:0] alu_s;
   logic [7:0] lit, pc;
   int         total = 0;
   int         bad   = 0;

   cu_sequencer_if #(.OPW(7), .DW(8), .PCW(8)) bus ();

   cu_sequencer dut (
      .clk   (clk),
      .rst   (rst),
      .im    (bus),
      .alu_z (alu_z),
      .alu_n (alu_n),
      .alu_c (alu_c),
      .LA    (LA),
      .LB    (LB),
      .SA    (SA),
      .SB    (SB),
      .alu_s (alu_s),
      .lit   (lit),
      .pc    (pc),
      .halt  (halt),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_fetch(input logic [6:0] op, input logic [7:0] l);
      bus.im_data = {op, l};
      bus.im_ack  = 1'b1;
      step();
   endtask

   task automatic exec_end(input logic z, input logic n, input logic c);
      alu_z = z;
      alu_n = n;
      alu_c = c;
      step();
   endtask

   task automatic ctl(input string tag, input logic la, input logic lb,
                      input logic [1:0] sa, input logic [1:0] sb,
                      input logic [2:0] s);
      chk({tag, "_ctl"}, {27'd0, LA, LB, SA, SB, alu_s},
          {27'd0, la, lb, sa, sb, s});
   endtask

   initial begin
      rst = 1'b1;
      alu_z = 1'b0; alu_n = 1'b0; alu_c = 1'b0;
      bus.im_ack  = 1'b1;
      bus.im_data = {7'h02, 8'h05};
      step();
      step();
      rst = 1'b0;
      chk("rst_pc", pc, 0);
      chk("rst_req", bus.im_req, 1);
      chk("rst_halt", halt, 0);
      chk("rst_err", err, 0);
      ctl("rst", 0, 0, 2'b00, 2'b00, 3'b000);
      chk("rst_lit", lit, 0);
      chk("rst_flags", {dut.flag_z, dut.flag_n, dut.flag_c}, 0);

      // MOV A,lit
      do_fetch(7'h02, 8'h05);
      ctl("t1", 1, 0, 2'b11, 2'b10, 3'b011);
      chk("t1_lit", lit, 5);
      chk("t1_req", bus.im_req, 0);
      exec_end(0, 0, 0);
      chk("t1_pc", pc, 1);

      // fetch stall
      bus.im_ack  = 1'b0;
      bus.im_data = {7'h04, 8'h33};
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_req", bus.im_req, 1);
         chk("t2_addr", bus.im_addr, 1);
         chk("t2_ld", {LA, LB}, 0);
         chk("t2_ir", dut.ir, 15'h0205);
      end
      do_fetch(7'h04, 8'h33);
      ctl("t2_add", 1, 0, 2'b00, 2'b00, 3'b000);
      exec_end(0, 0, 1);
      chk("t2_pc", pc, 2);
      chk("t2_c", dut.flag_c, 1);

      // flags: SUB sets Z, MOV holds it
      do_fetch(7'h08, 8'h00);
      ctl("t3_sub", 1, 0, 2'b00, 2'b00, 3'b001);
      exec_end(1, 0, 0);
      chk("t3_z", dut.flag_z, 1);
      chk("t3_c", dut.flag_c, 0);
      do_fetch(7'h00, 8'h00);
      ctl("t3_mov", 1, 0, 2'b11, 2'b00, 3'b011);
      exec_end(0, 1, 1);
      chk("t3_zhold", {dut.flag_z, dut.flag_n, dut.flag_c}, 3'b100);
      chk("t3_pc", pc, 4);
`ifdef CU_JUMP_EN
      do_fetch(7'h41, 8'h20);
      ctl("t3_jeq", 0, 0, 2'b00, 2'b00, 3'b000);
      exec_end(0, 0, 0);
      chk("t3_jeq_taken", pc, 8'h20);
      do_fetch(7'h08, 8'h00);
      exec_end(0, 0, 0);
      do_fetch(7'h41, 8'h20);
      exec_end(0, 0, 0);
      chk("t3_jeq_not", pc, 8'h22);
      chk("t3_err", err, 0);
`else
      do_fetch(7'h40, 8'h10);
      exec_end(0, 0, 0);
      chk("t3_jmp_ill", err, 1);
      chk("t3_jmp_pc", pc, 5);
`endif

      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t4_rst_err", err, 0);
      for (int i = 0; i < 255; i++) begin
         do_fetch(7'h00, 8'h00);
         exec_end(0, 0, 0);
      end
      chk("t4_pc_ff", pc, 8'hFF);
      do_fetch(7'h04, 8'h00);
      exec_end(0, 0, 0);
      chk("t4_wrap", pc, 8'h00);
      chk("t4_noerr", err, 0);
      do_fetch(7'h50, 8'h00);
      ctl("t4_ill", 0, 0, 2'b00, 2'b00, 3'b000);
      exec_end(0, 0, 0);
      chk("t4_err", err, 1);
      chk("t4_ill_pc", pc, 1);
      do_fetch(7'h1E, 8'h00);
      ctl("t4_shl", 0, 1, 2'b00, 2'b00, 3'b110);
      exec_end(0, 0, 0);
      chk("t4_sticky", err, 1);
      do_fetch(7'h24, 8'h07);
      ctl("t4_inc", 0, 1, 2'b01, 2'b10, 3'b000);
      exec_end(0, 0, 0);
      do_fetch(7'h13, 8'h01);
      ctl("t4_orv3", 0, 1, 2'b01, 2'b10, 3'b011);
      exec_end(0, 0, 0);
      chk("t4_pc4", pc, 4);
      chk("t4_sticky2", err, 1);

      // halt
      do_fetch(7'h7F, 8'h00);
      ctl("t5_hlt", 0, 0, 2'b00, 2'b00, 3'b000);
      chk("t5_halt_exec", halt, 0);
      exec_end(0, 0, 0);
      chk("t5_halt", halt, 1);
      chk("t5_req", bus.im_req, 0);
      for (int i = 0; i < 5; i++) step();
      chk("t5_halt_hold", {halt, bus.im_req}, 2'b10);
      chk("t5_pc_hold", pc, 4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_rst_pc", pc, 0);
      chk("t5_rst", {halt, bus.im_req}, 2'b01);

      // reset during EXEC
      do_fetch(7'h08, 8'h00);
      exec_end(1, 1, 1);
      chk("t6_flags1", {dut.flag_z, dut.flag_n, dut.flag_c}, 3'b111);
      do_fetch(7'h04, 8'h00);
      chk("t6_la_pre", LA, 1);
      rst = 1'b1;
      #1;
      chk("t6_la_gated", LA, 0);
      step();
      chk("t6_pc", pc, 0);
      chk("t6_flags0", {dut.flag_z, dut.flag_n, dut.flag_c}, 0);
      chk("t6_req", bus.im_req, 1);
      rst = 1'b0;
      do_fetch(7'h40, 8'h10);
      exec_end(0, 0, 0);
`ifdef CU_JUMP_EN
      chk("t6_jmp_pc", pc, 8'h10);
      chk("t6_jmp_err", err, 0);
`else
      chk("t6_jmp_err", err, 1);
      chk("t6_jmp_pc", pc, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
